ofm_flattener: RTL and testbench
================================

// Module: ofm_flattener
// PURPOSE
//  Collects OFM rows from NUM_CH PE output ports into per-channel FIFOs and drains them in strict
//  round-robin order (ch0..chN-1, wrap) onto one valid/ready stream feeding the AXI write master.
//  Issues the write-master request with a 4 KiB-aligned base and a size padded to match.
//  Tracks end-of-convolution against wmst_done. Sits between the PE array and the wmst/AXI bridge.
//  Parametrised successor of the fixed 4x512 flattener.
// PARAMETERS
//  NUM_CH    4    channel count (>=2); ptr width = $clog2(NUM_CH)
//  DATA_W    512  beat width in bits
//  FIFO_AW   10   per-channel FIFO depth = 2**FIFO_AW entries
//  PAGE_BITS 12   write-base alignment (4 KiB)
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              async active-low reset
//  g_stall        in   1              global stall; blocks pushes until end_conv has been seen
//  op_start       in   1              start pulse; latches ofm_size and wmst_offset
//  ofm_size       in   32             output bytes for this op
//  in_data        in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//  in_valid       in   NUM_CH         per-channel push strobe
//  end_conv       in   1              last PE output issued (pulse)
//  out_data       out  DATA_W         stream data (head of FIFO[ptr])
//  out_valid      out  1              stream valid
//  out_ready      in   1              stream ready
//  wmst_offset    in   64             byte destination address
//  wmst_done      in   1              write master finished transfer
//  wmst_req       out  1              1-cycle request pulse
//  wmst_addr      out  64             latched base, low PAGE_BITS zero
//  wmst_xfer_size out  64             latched size in bytes
//  busy           out  1              transfer outstanding (write_buffer_wait)
//  stall          out  1              any channel FIFO full
//  overflow       out  1              sticky: push attempted on a full FIFO
//  beat_cnt       out  32             handshakes since last op_start
// BEHAVIOUR
//  Reset: all outputs 0, ptr=0, FSM=IDLE, FIFOs empty, end_seen=0.
//  Push: FIFO[i] push = in_valid[i] & !(g_stall & !end_seen) & !full[i]. If full, drop the
//   beat and set overflow (sticky; cleared only by reset or op_start).
//  Stream: out_valid = !empty[ptr], combinational from FWFT head. Pop FIFO[ptr] and advance ptr on
//   out_valid & out_ready. ptr wraps NUM_CH-1 -> 0. No skipping of empty channels.
//   out_data is held stable while out_valid & !out_ready.
//  beat_cnt: +1 per handshake, cleared on accepted op_start, wraps at 2^32.
//  Address: on accepted op_start:
//   wmst_addr <= {wmst_offset[63:PAGE_BITS], 0}
//   wmst_xfer_size <= wmst_offset[PAGE_BITS-1:0] + ofm_size, zero-extended to 64 bits
//  FSM:
//   IDLE -(op_start)-> REQ
//   REQ: wmst_req=1 for exactly 1 cycle -> XFER
//   XFER: end_seen set by end_conv. Leave to IDLE when (end_conv|end_seen) & wmst_done,
//    then clear end_seen.
//   busy = (FSM != IDLE).
//  Simultaneous events: end_conv & wmst_done in the same cycle -> IDLE. op_start outside IDLE is
//   ignored (no relatch, no req). wmst_done without end_seen is ignored.
//  Reset mid-op: async return to reset state; FIFO contents are discarded.
//  stall = |full, combinational. Latency in_valid -> out_valid = 1 cycle (FIFO write, FWFT).
// CONFIGURATION
//  `FLATTENER_PERF_CNT_EN defined:
//   adds out port perf_bp_cycles[31:0], counting cycles with out_valid & !out_ready
//   adds out port perf_stall_cycles[31:0], counting cycles with stall=1
//   both counters clear on op_start and saturate at all-ones
//  Undefined: the ports and logic are absent.
// STRUCTURE
//  Package flattener_pkg: state enum {IDLE, REQ, XFER}; localparam PAGE_BYTES = 1<<PAGE_BITS;
//   localparam PTR_W = $clog2(NUM_CH).
//  Sub-module ofm_chan_fifo (FWFT sync FIFO, DATA_W x 2**FIFO_AW), instantiated NUM_CH times.
//   Ports: push, pop, wdata, rdata, empty, full, count. Pop on empty and push on full are no-ops.
// TESTING
//  1 NUM_CH=4; push 1 beat on each ch (data=ch id), ready=1 -> out 0,1,2,3; ptr back at 0;
//    beat_cnt=4.
//  2 Only ch1 holds data, ptr=0 -> out_valid=0 (no skip). After ch0 push -> ch0 beat, then ch1 beat.
//  3 op_start with offset=0x1234_5F40, ofm_size=0x2000 -> wmst_addr=0x1234_5000,
//    xfer_size=0x2F40, wmst_req high exactly 1 cycle later for 1 cycle, busy=1.
//  4 end_conv and wmst_done in same cycle -> busy=0 next cycle. Also: wmst_done alone -> busy stays 1.
//  5 g_stall=1 with end_seen=0 -> no pushes. After end_conv, pushes resume under g_stall.
//    Fill ch2 to 2**FIFO_AW -> stall=1. Extra push -> overflow=1, count unchanged.
//  6 Hold ready=0 for 5 cycles with valid=1 -> out_data stable; perf_bp_cycles=5
//    (macro on only). Assert rst_n mid-XFER -> all outputs 0.

Source files
------------

// File: rtl/flattener_pkg.sv
// Shared types and defaults for the OFM flattener slice.
// Contents: FSM state type, default geometry, write-base alignment constants.
package flattener_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StXfer = 2'd2
    } flat_state_e;

    localparam int unsigned NUM_CH_DEFAULT    = 4;
    localparam int unsigned DATA_W_DEFAULT    = 512;
    localparam int unsigned FIFO_AW_DEFAULT   = 10;
    localparam int unsigned PAGE_BITS_DEFAULT = 12;
    localparam int unsigned PAGE_BYTES        = 1 << PAGE_BITS_DEFAULT;
    localparam int unsigned PTR_W             = $clog2(NUM_CH_DEFAULT);

endpackage

// File: rtl/ofm_chan_fifo.sv
// First-word-fall-through synchronous FIFO, DATA_W x 2**FIFO_AW, one per PE channel.
// Ports: clk, rst_n (async active-low), push/wdata (write), pop/rdata (read, rdata valid
// whenever !empty), empty, full, count (occupancy). Push on full and pop on empty are no-ops.
module ofm_chan_fifo #(
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned FIFO_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [FIFO_AW:0]  count
);

    localparam int unsigned Depth = 1 << FIFO_AW;

    logic [DATA_W-1:0]  mem [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_AW+1)'(Depth));
    assign count   = count_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ofm_flattener.sv
// OFM flattener: gathers PE channel rows into per-channel FIFOs and drains them in strict
// round-robin order onto a single valid/ready stream; issues the write-master request with a
// page-aligned base and matching padded size; tracks end-of-convolution against wmst_done.
// Ports: clk, rst_n, g_stall, op_start, ofm_size, in_data/in_valid (per channel),
// end_conv, out_data/out_valid/out_ready (stream), wmst_offset, wmst_done, wmst_req,
// wmst_addr, wmst_xfer_size, busy, stall, overflow, beat_cnt.
// Build option FLATTENER_PERF_CNT_EN adds perf_bp_cycles and perf_stall_cycles.
module ofm_flattener
    import flattener_pkg::*;
#(
    parameter int unsigned NUM_CH    = NUM_CH_DEFAULT,
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned FIFO_AW   = FIFO_AW_DEFAULT,
    parameter int unsigned PAGE_BITS = PAGE_BITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     g_stall,
    input  logic                     op_start,
    input  logic [31:0]              ofm_size,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic                     end_conv,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [63:0]              wmst_offset,
    input  logic                     wmst_done,
    output logic                     wmst_req,
    output logic [63:0]              wmst_addr,
    output logic [63:0]              wmst_xfer_size,
    output logic                     busy,
    output logic                     stall,
    output logic                     overflow,
    output logic [31:0]              beat_cnt
`ifdef FLATTENER_PERF_CNT_EN
    ,
    output logic [31:0]              perf_bp_cycles,
    output logic [31:0]              perf_stall_cycles
`endif
);

    localparam int unsigned PtrW  = $clog2(NUM_CH);
    localparam int unsigned Depth = 1 << FIFO_AW;

    flat_state_e state_q, state_d;
    logic [PtrW-1:0]   ptr_q;
    logic              end_seen_q;
    logic              start_acc, leave_xfer, handshake, push_block;
    logic [NUM_CH-1:0] push_req, push, pop, empty, full, at_depth;
    logic [DATA_W-1:0] rdata [NUM_CH];
    logic [FIFO_AW:0]  count [NUM_CH];

    // Channel FIFOs
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        ofm_chan_fifo #(
            .DATA_W  (DATA_W),
            .FIFO_AW (FIFO_AW)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (in_data[i*DATA_W +: DATA_W]),
            .rdata (rdata[i]),
            .empty (empty[i]),
            .full  (full[i]),
            .count (count[i])
        );
        assign at_depth[i] = (count[i] == (FIFO_AW+1)'(Depth));
        assign pop[i]      = handshake & (ptr_q == PtrW'(i));
    end

    // g_stall only holds off the PE until the last output has been announced.
    assign push_block = g_stall & ~end_seen_q;
    assign push_req   = in_valid & {NUM_CH{~push_block}};
    assign push       = push_req & ~full;
    assign stall      = |at_depth;

    // Stream side: no skipping, the pointer waits on an empty channel.
    assign out_valid = ~empty[ptr_q];
    assign out_data  = out_valid ? rdata[ptr_q] : '0;
    assign handshake = out_valid & out_ready;

    assign start_acc  = op_start & (state_q == StIdle);
    assign leave_xfer = (state_q == StXfer) & (end_conv | end_seen_q) & wmst_done;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (op_start) state_d = StReq;
            StReq:   state_d = StXfer;
            StXfer:  if (leave_xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        wmst_req = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StReq:   wmst_req = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            end_seen_q     <= 1'b0;
            overflow       <= 1'b0;
            beat_cnt       <= '0;
            wmst_addr      <= '0;
            wmst_xfer_size <= '0;
        end else begin
            if (handshake) begin
                ptr_q <= (ptr_q == PtrW'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
            end

            if (leave_xfer)                        end_seen_q <= 1'b0;
            else if (state_q == StXfer && end_conv) end_seen_q <= 1'b1;

            if (start_acc) begin
                beat_cnt       <= '0;
                wmst_addr      <= {wmst_offset[63:PAGE_BITS], {PAGE_BITS{1'b0}}};
                // Size grows by the sub-page offset dropped from the base.
                wmst_xfer_size <= {{(64-PAGE_BITS){1'b0}}, wmst_offset[PAGE_BITS-1:0]}
                                + {32'b0, ofm_size};
            end else if (handshake) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (|(push_req & full)) overflow <= 1'b1;
            else if (start_acc)     overflow <= 1'b0;
        end
    end

`ifdef FLATTENER_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bp_cycles    <= '0;
            perf_stall_cycles <= '0;
        end else if (start_acc) begin
            perf_bp_cycles    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (out_valid && !out_ready && perf_bp_cycles != '1) begin
                perf_bp_cycles <= perf_bp_cycles + 1'b1;
            end
            if (stall && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ofm_flattener.sv
// Scoreboard bench for ofm_flattener: stimulus queues expected stream beats, a negedge monitor
// pops and compares on every handshake; register-style outputs are checked directly.
module tb_ofm_flattener;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 4;
    localparam int unsigned DEP = 1 << AW;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                g_stall, op_start, end_conv, out_ready, wmst_done;
    logic [31:0]         ofm_size;
    logic [NCH*DW-1:0]   in_data;
    logic [NCH-1:0]      in_valid;
    logic [DW-1:0]       out_data;
    logic                out_valid, wmst_req, busy, stall, overflow;
    logic [63:0]         wmst_offset, wmst_addr, wmst_xfer_size;
    logic [31:0]         beat_cnt;
`ifdef FLATTENER_PERF_CNT_EN
    logic [31:0]         perf_bp_cycles, perf_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    ofm_flattener #(
        .NUM_CH    (NCH),
        .DATA_W    (DW),
        .FIFO_AW   (AW),
        .PAGE_BITS (12)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .g_stall        (g_stall),
        .op_start       (op_start),
        .ofm_size       (ofm_size),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .end_conv       (end_conv),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .wmst_offset    (wmst_offset),
        .wmst_done      (wmst_done),
        .wmst_req       (wmst_req),
        .wmst_addr      (wmst_addr),
        .wmst_xfer_size (wmst_xfer_size),
        .busy           (busy),
        .stall          (stall),
        .overflow       (overflow),
        .beat_cnt       (beat_cnt)
`ifdef FLATTENER_PERF_CNT_EN
        ,
        .perf_bp_cycles    (perf_bp_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int ch, input logic [DW-1:0] val);
        in_data[ch*DW +: DW] = val;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_unexpected actual=%0h required=none", out_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL stream_data actual=%0h required=%0h", out_data, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; g_stall = 1'b0; op_start = 1'b0; end_conv = 1'b0; out_ready = 1'b0;
        wmst_done = 1'b0; ofm_size = '0; in_data = '0; in_valid = '0; wmst_offset = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_wmst_addr", wmst_addr, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: one beat per channel, data = channel id, drains 0,1,2,3
        out_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            set_beat(c, DW'(c));
            exp_q.push_back(DW'(c));
        end
        in_valid = 4'hF;
        step();
        in_valid = '0;
        wait_drain(20);
        chk("t1_beat_cnt", 64'(beat_cnt), 64'd4);

        // 2: only ch1 has data while ptr is at 0 -> nothing presented
        set_beat(1, 32'h11);
        in_valid = 4'b0010;
        step();
        in_valid = '0;
        chk("t2_no_skip_a", 64'(out_valid), 64'd0);
        step();
        chk("t2_no_skip_b", 64'(out_valid), 64'd0);
        set_beat(0, 32'h10);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h11);
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        wait_drain(20);
        set_beat(2, 32'h12);
        set_beat(3, 32'h13);
        exp_q.push_back(32'h12);
        exp_q.push_back(32'h13);
        in_valid = 4'b1100;
        step();
        in_valid = '0;
        wait_drain(20);
        chk("t2_beat_cnt", 64'(beat_cnt), 64'd8);

        // 3: request with page-aligned base and padded size
        wmst_offset = 64'h1234_5F40;
        ofm_size    = 32'h2000;
        op_start    = 1'b1;
        chk("t3_req_before", 64'(wmst_req), 64'd0);
        step();
        op_start = 1'b0;
        chk("t3_req_high", 64'(wmst_req), 64'd1);
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_addr", wmst_addr, 64'h1234_5000);
        chk("t3_size", wmst_xfer_size, 64'h2F40);
        chk("t3_beat_cnt_clr", 64'(beat_cnt), 64'd0);
        step();
        chk("t3_req_one_cycle", 64'(wmst_req), 64'd0);
        chk("t3_busy_xfer", 64'(busy), 64'd1);
        // op_start while busy is ignored
        wmst_offset = 64'hFFFF_F123;
        op_start    = 1'b1;
        step();
        op_start = 1'b0;
        chk("t3_ignored_addr", wmst_addr, 64'h1234_5000);
        chk("t3_ignored_req", 64'(wmst_req), 64'd0);

        // 4: wmst_done alone ignored; end_conv + wmst_done together ends the op
        wmst_done = 1'b1;
        step();
        wmst_done = 1'b0;
        chk("t4_done_alone", 64'(busy), 64'd1);
        end_conv  = 1'b1;
        wmst_done = 1'b1;
        step();
        end_conv  = 1'b0;
        wmst_done = 1'b0;
        chk("t4_idle", 64'(busy), 64'd0);

        // 5: g_stall gating, fill to depth, overflow
        wmst_offset = 64'h0;
        ofm_size    = 32'h100;
        op_start    = 1'b1;
        step();
        op_start = 1'b0;
        step();
        out_ready = 1'b0;
        g_stall   = 1'b1;
        set_beat(0, 32'hBAD);
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        chk("t5_gstall_block", 64'(out_valid), 64'd0);
        end_conv = 1'b1;
        step();
        end_conv = 1'b0;
        chk("t5_end_conv_busy", 64'(busy), 64'd1);
        for (int k = 0; k < DEP; k++) begin
            for (int c = 0; c < NCH; c++) begin
                set_beat(c, DW'((c << 8) | k));
                exp_q.push_back(DW'((c << 8) | k));
            end
            in_valid = 4'hF;
            if (k == DEP - 1) chk("t5_stall_before_full", 64'(stall), 64'd0);
            step();
        end
        in_valid = '0;
        chk("t5_stall_full", 64'(stall), 64'd1);
        chk("t5_no_ovf_yet", 64'(overflow), 64'd0);
        set_beat(2, 32'hDEAD);
        in_valid = 4'b0100;
        step();
        in_valid = '0;
        chk("t5_overflow", 64'(overflow), 64'd1);
        g_stall   = 1'b0;
        out_ready = 1'b1;
        wait_drain(200);
        step();
        chk("t5_dropped_beat", 64'(out_valid), 64'd0);
        chk("t5_ovf_sticky", 64'(overflow), 64'd1);
        chk("t5_beat_cnt", 64'(beat_cnt), 64'(NCH * DEP));
        wmst_done = 1'b1;
        step();
        wmst_done = 1'b0;
        chk("t5_idle", 64'(busy), 64'd0);

        // 6: backpressure holds data; then async reset mid-transfer
        op_start = 1'b1;
        step();
        op_start  = 1'b0;
        chk("t6_ovf_clr", 64'(overflow), 64'd0);
        out_ready = 1'b0;
        set_beat(0, 32'h55);
        exp_q.push_back(32'h55);
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_valid", 64'(out_valid), 64'd1);
            chk("t6_hold_data", 64'(out_data), 64'h55);
            step();
        end
`ifdef FLATTENER_PERF_CNT_EN
        chk("t6_perf_bp", 64'(perf_bp_cycles), 64'd5);
`endif
        out_ready = 1'b1;
        wait_drain(10);
        out_ready = 1'b0;
        set_beat(1, 32'h66);
        in_valid = 4'b0010;
        step();
        in_valid = '0;
        chk("t6_pre_rst_valid", 64'(out_valid), 64'd1);
        chk("t6_pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_data", 64'(out_data), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_req", 64'(wmst_req), 64'd0);
        chk("t6_rst_addr", wmst_addr, 64'd0);
        chk("t6_rst_size", wmst_xfer_size, 64'd0);
        chk("t6_rst_beat", 64'(beat_cnt), 64'd0);
        chk("t6_rst_stall", 64'(stall), 64'd0);
        chk("t6_rst_ovf", 64'(overflow), 64'd0);
`ifdef FLATTENER_PERF_CNT_EN
        chk("t6_rst_perf_bp", 64'(perf_bp_cycles), 64'd0);
        chk("t6_rst_perf_stall", 64'(perf_stall_cycles), 64'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        chk("t6_discarded", 64'(out_valid), 64'd0);
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
